// File: rtl/xs3_dec_pkg.sv
// Shared types and the nibble decode function for the sequential excess-3/BCD decoder.
// Optional invalid-digit counter in the top is enabled by defining XS3DEC_ERRCNT_EN.
package xs3_dec_pkg;

  typedef enum logic {
    CM_BCD = 1'b0,
    CM_XS3 = 1'b1
  } code_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int ERR_CNT_W = 8;

  // Returns {err, onehot[9:0]} with active-high one-hot; an invalid code yields no line.
  function automatic logic [10:0] decode_nibble(input logic [3:0] code, input code_mode_e mode);
    logic [3:0] v;
    logic       ok;
    if (mode == CM_XS3) begin
      ok = (code >= 4'd3) && (code <= 4'd12);
      v  = code - 4'd3;
    end else begin
      ok = (code <= 4'd9);
      v  = code;
    end
    if (ok) begin
      decode_nibble = {1'b0, 10'd1 << v};
    end else begin
      decode_nibble = {1'b1, 10'd0};
    end
  endfunction

endpackage

// File: rtl/xs3_digit_dec.sv
// Combinational single-digit decoder: code nibble -> 10 decimal lines plus invalid-code flag.
// Blanking suppresses every line but leaves the error flag intact.
module xs3_digit_dec
  import xs3_dec_pkg::*;
#(
  parameter int CODE_MODE  = 1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] code_i,
  input  logic       blank_i,
  output logic [9:0] y_o,
  output logic       err_o
);

  localparam code_mode_e MODE = (CODE_MODE != 0) ? CM_XS3 : CM_BCD;

  logic [10:0] dec_s;
  logic [9:0]  act_s;

  assign dec_s = decode_nibble(code_i, MODE);
  assign act_s = blank_i ? 10'd0 : dec_s[9:0];
  assign y_o   = ACTIVE_LOW ? ~act_s : act_s;
  assign err_o = dec_s[10];

endmodule

// File: rtl/xs3_dec_decoder_seq.sv
// Registered multi-digit decoder: takes NDIG nibbles per handshake, emits one decoded digit per
// cycle LSB first. Define XS3DEC_ERRCNT_EN to enable the saturating invalid-digit counter.
module xs3_dec_decoder_seq
  import xs3_dec_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int CODE_MODE  = 1,
  parameter bit ACTIVE_LOW = 1'b1,
  localparam int DW        = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [4*NDIG-1:0]     IN_DATA,
  input  logic                  BLANK,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [9:0]            Y,
  output logic [DW-1:0]         OUT_DIG,
  output logic                  OUT_LAST,
  output logic                  OUT_ERR,
  output logic [ERR_CNT_W-1:0]  ERR_CNT
);

  localparam logic [DW-1:0] LAST_IDX = DW'(NDIG - 1);
  localparam logic [9:0]    Y_IDLE   = ACTIVE_LOW ? 10'h3FF : 10'h000;

  state_e              state_q, state_d;
  logic [4*NDIG-1:0]   data_q, data_d;
  logic                blank_q, blank_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic                valid_q, valid_d;
  logic [9:0]          y_q, y_d;
  logic                last_q, last_d;
  logic                err_q, err_d;

  logic                out_hs, in_ready, accept, advance;
  logic [4*NDIG-1:0]   src_data;
  logic                src_blank;
  logic [DW-1:0]       src_idx;
  logic [3:0]          src_nib;
  logic [9:0]          dec_y;
  logic                dec_err;

  assign out_hs   = valid_q & OUT_READY;
  assign in_ready = ~RST & ((state_q == ST_IDLE) | (out_hs & last_q));
  assign accept   = IN_VALID & in_ready;
  assign advance  = out_hs & ~last_q;

  // A freshly accepted word always starts at digit 0; otherwise step through the held word.
  assign src_data  = accept ? IN_DATA : data_q;
  assign src_blank = accept ? BLANK : blank_q;
  assign src_idx   = accept ? '0 : dig_q + DW'(1);
  assign src_nib   = 4'(src_data >> {src_idx, 2'b00});

  xs3_digit_dec #(
    .CODE_MODE  (CODE_MODE),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_digit_dec (
    .code_i  (src_nib),
    .blank_i (src_blank),
    .y_o     (dec_y),
    .err_o   (dec_err)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    blank_d = blank_q;
    dig_d   = dig_q;
    valid_d = valid_q;
    y_d     = y_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (out_hs && last_q) state_d = accept ? ST_RUN : ST_IDLE;
        else                  state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept || advance) begin
      data_d  = src_data;
      blank_d = src_blank;
      dig_d   = src_idx;
      valid_d = 1'b1;
      y_d     = dec_y;
      last_d  = (src_idx == LAST_IDX);
      err_d   = dec_err;
    end else if (out_hs) begin
      valid_d = 1'b0;
      y_d     = Y_IDLE;
      dig_d   = '0;
      last_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      blank_q <= 1'b0;
      dig_q   <= '0;
      valid_q <= 1'b0;
      y_q     <= Y_IDLE;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      blank_q <= blank_d;
      dig_q   <= dig_d;
      valid_q <= valid_d;
      y_q     <= y_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

`ifdef XS3DEC_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_hs && err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign ERR_CNT = err_cnt_q;
`else
  assign ERR_CNT = {ERR_CNT_W{1'b0}};
`endif

  assign IN_READY  = in_ready;
  assign OUT_VALID = valid_q;
  assign Y         = y_q;
  assign OUT_DIG   = dig_q;
  assign OUT_LAST  = last_q;
  assign OUT_ERR   = err_q;

endmodule

// File: tb/tb_xs3_dec_decoder_seq.sv
// Bench: an XS-3 and a BCD instance share stimulus; a digit-queue reference model predicts outputs.
module tb_xs3_dec_decoder_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, blank, out_ready;
  logic [15:0] in_data;

  logic       x_in_ready, x_out_valid, x_last, x_err;
  logic [9:0] x_y;
  logic [1:0] x_dig;
  logic [7:0] x_cnt;
  logic       b_in_ready, b_out_valid, b_last, b_err;
  logic [9:0] b_y;
  logic [1:0] b_dig;
  logic [7:0] b_cnt;

  always #5 clk = ~clk;

  xs3_dec_decoder_seq #(.NDIG(4), .CODE_MODE(1), .ACTIVE_LOW(1'b1)) u_dut_xs3 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(x_in_ready), .IN_DATA(in_data),
    .BLANK(blank), .OUT_VALID(x_out_valid), .OUT_READY(out_ready), .Y(x_y), .OUT_DIG(x_dig),
    .OUT_LAST(x_last), .OUT_ERR(x_err), .ERR_CNT(x_cnt));

  xs3_dec_decoder_seq #(.NDIG(4), .CODE_MODE(0), .ACTIVE_LOW(1'b1)) u_dut_bcd (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(b_in_ready), .IN_DATA(in_data),
    .BLANK(blank), .OUT_VALID(b_out_valid), .OUT_READY(out_ready), .Y(b_y), .OUT_DIG(b_dig),
    .OUT_LAST(b_last), .OUT_ERR(b_err), .ERR_CNT(b_cnt));

  typedef struct {
    logic [9:0] yx;
    logic       ex;
    logic [9:0] yb;
    logic       eb;
    int         dig;
    logic       last;
  } dig_t;

  dig_t q[$];
  int   cnt_x, cnt_b;
  bit   idle_y_chk;
  int   n_chk, n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {err, y} for one nibble, straight from the decimal-code rules.
  function automatic logic [10:0] ref_digit(input int nib, input bit xs3, input bit blk);
    int v;
    bit bad;
    v   = xs3 ? nib - 3 : nib;
    bad = (v < 0) || (v > 9);
    if (bad || blk) return {bad, 10'h3FF};
    return {1'b0, 10'h3FF ^ (10'd1 << v)};
  endfunction

  function automatic bit exp_in_ready();
    return !rst && (q.size() == 0 || (q.size() == 1 && out_ready));
  endfunction

  task automatic check_outputs();
    bit ev;
    ev = (q.size() > 0);
    check_eq("x_in_ready", 32'(x_in_ready), 32'(exp_in_ready()));
    check_eq("b_in_ready", 32'(b_in_ready), 32'(exp_in_ready()));
    check_eq("x_out_valid", 32'(x_out_valid), 32'(ev));
    check_eq("b_out_valid", 32'(b_out_valid), 32'(ev));
    if (ev) begin
      check_eq("x_y", 32'(x_y), 32'(q[0].yx));
      check_eq("x_err", 32'(x_err), 32'(q[0].ex));
      check_eq("x_dig", 32'(x_dig), 32'(q[0].dig));
      check_eq("x_last", 32'(x_last), 32'(q[0].last));
      check_eq("b_y", 32'(b_y), 32'(q[0].yb));
      check_eq("b_err", 32'(b_err), 32'(q[0].eb));
      check_eq("b_dig", 32'(b_dig), 32'(q[0].dig));
      check_eq("b_last", 32'(b_last), 32'(q[0].last));
    end else if (idle_y_chk) begin
      check_eq("x_y_idle", 32'(x_y), 32'h3FF);
      check_eq("b_y_idle", 32'(b_y), 32'h3FF);
      check_eq("x_last_idle", 32'(x_last), 32'h0);
    end
`ifdef XS3DEC_ERRCNT_EN
    check_eq("x_err_cnt", 32'(x_cnt), 32'(cnt_x));
    check_eq("b_err_cnt", 32'(b_cnt), 32'(cnt_b));
`else
    check_eq("x_err_cnt", 32'(x_cnt), 32'h0);
    check_eq("b_err_cnt", 32'(b_cnt), 32'h0);
`endif
  endtask

  task automatic update_model();
    bit acc;
    dig_t d;
    logic [10:0] rx, rb;
    if (rst) begin
      q.delete();
      cnt_x = 0;
      cnt_b = 0;
      idle_y_chk = 1'b1;
    end else begin
      acc = in_valid && exp_in_ready();
      if (q.size() > 0 && out_ready) begin
        if (q[0].ex && cnt_x < 255) cnt_x++;
        if (q[0].eb && cnt_b < 255) cnt_b++;
        void'(q.pop_front());
      end
      if (acc) begin
        idle_y_chk = 1'b0;
        for (int i = 0; i < 4; i++) begin
          rx     = ref_digit(int'((in_data >> (4 * i)) & 16'hF), 1'b1, blank);
          rb     = ref_digit(int'((in_data >> (4 * i)) & 16'hF), 1'b0, blank);
          d.yx   = rx[9:0];
          d.ex   = rx[10];
          d.yb   = rb[9:0];
          d.eb   = rb[10];
          d.dig  = i;
          d.last = (i == 3);
          q.push_back(d);
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic b, input logic r,
                      input logic rs);
    in_valid  = v;
    in_data   = d;
    blank     = b;
    out_ready = r;
    rst       = rs;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cnt_x = 0;
    cnt_b = 0;
    idle_y_chk = 1'b1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 16'h0;
    blank = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

    // Plain word, full-rate drain.
    step(1'b1, 16'hC543, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

    // All-invalid XS-3 codes.
    step(1'b1, 16'h0F21, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

    // Backpressure on digit 1.
    step(1'b1, 16'hC543, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

    // Back-to-back words with IN_VALID held high.
    step(1'b1, 16'h4567, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h89AB, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

    // Reset mid-word after digit 1 handshake.
    step(1'b1, 16'hC543, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

    // BCD digits, unblanked then blanked.
    step(1'b1, 16'h9870, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h9870, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

    // Randomised traffic with random backpressure and rare resets.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom()), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
